// File: rtl/mul_seq_arbiter.sv
// mul_seq_arbiter
//   One iterative shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH, unsigned)
//   shared by NUM_REQ requesters. Round-robin grant in IDLE, one multiply
//   in flight, result held on a valid/ready port tagged with requester id.
//
//   Optional feature: define MUL_ZERO_BYPASS_EN to have a zero operand go
//   straight to DONE with product 0 (response the cycle after accept).
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_multiplicand  packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_multiplier    packed operands, same packing
//   rsp_valid/ready   result handshake, result held until accepted
//   rsp_id            requester that owns rsp_product
//   rsp_product       unsigned 2*WIDTH product
//   busy              high whenever the FSM is not IDLE
module mul_seq_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_multiplicand,
    input  logic [NUM_REQ*WIDTH-1:0]   req_multiplier,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [2*WIDTH-1:0]         rsp_product,
    output logic                       busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [ID_W-1:0]      grant, grant_nxt;
    logic                 grant_vld;
    logic [ID_W:0]        idx_w;
    logic                 accept;
    logic [WIDTH-1:0]     sel_mcand, sel_mplier;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH-1:0]     acc_sh, mplier_sh;

    // Round-robin search starting at rr_ptr. Walking offsets from high to
    // low lets the closest valid requester win by being assigned last.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx_w     = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            idx_w = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx_w >= (ID_W+1)'(NUM_REQ))
                idx_w = idx_w - (ID_W+1)'(NUM_REQ);
            if (req_valid[idx_w[ID_W-1:0]]) begin
                grant     = idx_w[ID_W-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    assign grant_nxt  = (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
    assign accept     = (state_q == S_IDLE) && grant_vld && !reset;
    assign sel_mcand  = req_multiplicand[int'(grant)*WIDTH +: WIDTH];
    assign sel_mplier = req_multiplier[int'(grant)*WIDTH +: WIDTH];

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[grant] = 1'b1;
    end

    // One shift-add step: add multiplicand into the upper half when the
    // current multiplier LSB is set, then shift {carry,acc,mplier} right.
    // The multiplier register fills with product low bits as it empties.
    assign add_sum   = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_sh    = add_sum[WIDTH:1];
    assign mplier_sh = {add_sum[0], mplier_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        prod_d   = prod_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mcand_d  = sel_mcand;
                    mplier_d = sel_mplier;
                    acc_d    = '0;
                    cnt_d    = '0;
                    id_d     = grant;
                    rr_ptr_d = grant_nxt;
`ifdef MUL_ZERO_BYPASS_EN
                    if ((sel_mcand == '0) || (sel_mplier == '0)) begin
                        state_d = S_DONE;
                        prod_d  = '0;
                    end else begin
                        state_d = S_MUL;
                    end
`else
                    state_d = S_MUL;
`endif
                end
            end
            S_MUL: begin
                acc_d    = acc_sh;
                mplier_d = mplier_sh;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_DONE;
                    prod_d  = {acc_sh, mplier_sh};
                end
            end
            S_DONE: begin
                if (rsp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            prod_q   <= prod_d;
        end
    end

    assign rsp_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign rsp_id      = id_q;
    assign rsp_product = prod_q;

endmodule

// File: tb/tb_mul_seq_arbiter.sv
module tb_mul_seq_arbiter;
    localparam int W = 16;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_multiplicand;
    logic [N*W-1:0]   req_multiplier;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [2*W-1:0]   rsp_product;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    mul_seq_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_multiplicand(req_multiplicand), .req_multiplier(req_multiplier),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef MUL_ZERO_BYPASS_EN
        return (a == 16'h0 || b == 16'h0) ? 1 : W + 1;
`else
        if (a == b) return W + 1;  // latency independent of operands
        return W + 1;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Single directed multiply: waits for grant, checks latency and result,
    // optionally stalls the response for 'hold' cycles, then consumes it.
    task automatic op(input int id, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] ep, input int hold);
        int w;
        int lat;
        logic [N-1:0] onehot;
        onehot = N'(1) << id;
        @(negedge clk);
        req_valid = '0; req_valid[id] = 1'b1; rsp_ready = 1'b0;
        req_multiplicand[id*W +: W] = a;
        req_multiplier[id*W +: W]   = b;
        #1;
        w = 0;
        while (req_ready !== onehot && w < 60) begin
            @(negedge clk); #1; w++;
        end
        chk("grant", 64'(req_ready), 64'(onehot));
        if (w >= 60) begin
            req_valid = '0;
            return;
        end
        @(posedge clk); #1;
        req_valid = '0;
        lat = 0;
        do begin
            lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 100);
        chk("latency", 64'(lat), 64'(exp_lat(a, b)));
        chk("rsp_id", 64'(rsp_id), 64'(id));
        chk("product", 64'(rsp_product), 64'(ep));
        for (int h = 0; h < hold; h++) begin
            req_valid = '1;
            #1;
            chk("hold_ready", 64'(req_ready), 64'(0));
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'(1));
            chk("hold_product", 64'(rsp_product), 64'(ep));
            chk("hold_id", 64'(rsp_id), 64'(id));
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_drop", 64'(rsp_valid), 64'(0));
        chk("idle_after_rsp", 64'(busy), 64'(0));
    endtask

    // Transaction-level reference: pending requests, round-robin pointer,
    // at most one outstanding multiply with its due cycle and a*b product.
    bit            pend[N];
    logic [15:0]   pa[N], pb[N];
    int            ptr;
    bit            have_op;
    int            op_id, op_due, cyc;
    logic [31:0]   op_p;
    int            grant_log[$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        ptr = 0; have_op = 1'b0; cyc = 0;
        grant_log.delete();
    endtask

    function automatic logic [15:0] rnd_opnd();
        if ($urandom_range(0, 7) == 0) return 16'h0;
        return 16'($urandom);
    endfunction

    task automatic run_engine(input int ncycles, input bit rr_mode);
        logic [N-1:0] exp_rdy;
        int g;
        for (int c = 0; c < ncycles; c++) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if (rr_mode) begin
                        pend[i] = 1'b1;
                        pa[i] = 16'(i + 2) * 16'h0101;
                        pb[i] = 16'(i + 3);
                    end else if ($urandom_range(0, 3) == 0) begin
                        pend[i] = 1'b1;
                        pa[i] = rnd_opnd();
                        pb[i] = rnd_opnd();
                    end
                end
                req_valid[i] = pend[i];
                req_multiplicand[i*W +: W] = pa[i];
                req_multiplier[i*W +: W]   = pb[i];
            end
            rsp_ready = rr_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = '0;
            g = -1;
            if (!have_op) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
                end
                if (g >= 0) exp_rdy = N'(1) << g;
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (have_op) begin
                chk("busy", 64'(busy), 64'(1));
                chk("rsp_valid", 64'(rsp_valid), 64'(cyc >= op_due));
                if (rsp_valid && rsp_ready) begin
                    chk("rsp_id", 64'(rsp_id), 64'(op_id));
                    chk("product", 64'(rsp_product), 64'(op_p));
                    have_op = 1'b0;
                end
            end else begin
                chk("idle_busy", 64'(busy), 64'(0));
                chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
            end
            if (g >= 0) begin
                have_op = 1'b1;
                op_id   = g;
                op_p    = 32'(pa[g]) * 32'(pb[g]);
                op_due  = cyc + exp_lat(pa[g], pb[g]);
                ptr     = (g + 1) % N;
                pend[g] = 1'b0;
                grant_log.push_back(g);
            end
        end
    endtask

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        int          hold;
    } vec_t;

    vec_t vt[8];

    initial begin
        int seen;
        int exp_rr[5];

        vt[0] = '{0, 16'h0082, 16'h0004, 32'h0000_0208, 0};
        vt[1] = '{2, 16'h0003, 16'h0002, 32'h0000_0006, 0};
        vt[2] = '{2, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0};
        vt[3] = '{1, 16'h0000, 16'h1234, 32'h0000_0000, 0};
        vt[4] = '{3, 16'h1234, 16'h5678, 32'h0626_0060, 0};
        vt[5] = '{1, 16'h8000, 16'h0002, 32'h0001_0000, 0};
        vt[6] = '{0, 16'h0001, 16'hFFFF, 32'h0000_FFFF, 5};
        vt[7] = '{3, 16'hABCD, 16'h0000, 32'h0000_0000, 0};

        reset = 1'b1;
        req_valid = '1;
        req_multiplicand = '0;
        req_multiplier = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_product", 64'(rsp_product), 64'(0));
        req_valid = '0;
        reset = 1'b0;

        for (int v = 0; v < 8; v++)
            op(vt[v].id, vt[v].a, vt[v].b, vt[v].p, vt[v].hold);

        // Reset in the middle of a multiply: no response, pointer cleared.
        @(negedge clk);
        req_valid = 4'b0010;
        req_multiplicand[1*W +: W] = 16'h1111;
        req_multiplier[1*W +: W]   = 16'h0003;
        seen = 0;
        #1;
        while (req_ready !== 4'b0010 && seen < 60) begin
            @(negedge clk); #1; seen++;
        end
        chk("mid_grant", 64'(req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_req_ready", 64'(req_ready), 64'(0));
        chk("mrst_rsp_id", 64'(rsp_id), 64'(0));
        chk("mrst_rsp_product", 64'(rsp_product), 64'(0));
        rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no_rsp_after_reset", 64'(seen), 64'(0));
        rsp_ready = 1'b0;
        // rr_ptr back at 0: requesters 1 and 3 both valid -> 1 wins
        req_valid = 4'b1010;
        req_multiplicand[3*W +: W] = 16'h0005;
        req_multiplier[3*W +: W]   = 16'h0005;
        #1;
        chk("rr_after_reset", 64'(req_ready), 64'(4'b0010));
        req_valid = '0;
        op(1, 16'h0007, 16'h0009, 32'd63, 0);

        // All requesters held valid: strict rotation 0,1,2,3,0.
        do_reset();
        model_reset();
        run_engine(100, 1'b1);
        exp_rr = '{0, 1, 2, 3, 0};
        chk("rr_grant_count", 64'(grant_log.size() >= 5), 64'(1));
        for (int i = 0; i < 5; i++)
            if (i < grant_log.size())
                chk("rr_order", 64'(grant_log[i]), 64'(exp_rr[i]));

        // Randomized traffic against the transaction model.
        do_reset();
        model_reset();
        run_engine(3000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
